// File: rtl/bcd_xs3_codec.sv
// Digit-serial BCD<->Excess-3 word converter. The result appears DIGITS cycles after acceptance.
// The result is held until out_ready; in_ready stays low from acceptance until the result drains.
module bcd_xs3_codec #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err,
  output logic [DIGITS-1:0]     out_err_mask
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    cap_data;
  logic            cap_mode;
  logic [IW-1:0]   idx;
  logic [3:0]      cur_dig;
  logic [3:0]      conv_dig;
  logic            cur_bad;
  logic            last_dig;
  logic            accept;

  assign accept   = (state == IDLE) && in_valid && in_ready;
  assign last_dig = (idx == IW'(DIGITS - 1));
  assign out_err  = |out_err_mask;

  always_comb begin
    cur_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) cur_dig = cap_data[4*i +: 4];
    end
  end

  // Any out-of-range digit becomes 4'hF and raises its mask bit.
  always_comb begin
    conv_dig = 4'hF;
    cur_bad  = 1'b1;
    if (!cap_mode) begin
      if (cur_dig <= 4'd9) begin
        conv_dig = cur_dig + 4'd3;
        cur_bad  = 1'b0;
      end
    end else if ((cur_dig >= 4'd3) && (cur_dig <= 4'd12)) begin
      conv_dig = cur_dig - 4'd3;
      cur_bad  = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONV;
      CONV:    if (last_dig) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so nothing
  // combinational reaches them from in_valid or out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data     <= '0;
      cap_mode     <= 1'b0;
      idx          <= '0;
      out_data     <= '0;
      out_err_mask <= '0;
    end else if (accept) begin
      cap_data     <= in_data;
      cap_mode     <= in_mode;
      idx          <= '0;
      out_data     <= '0;
      out_err_mask <= '0;
    end else if (state == CONV) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx == IW'(i)) begin
          out_data[4*i +: 4] <= conv_dig;
          out_err_mask[i]    <= cur_bad;
        end
      end
      idx <= last_dig ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_xs3_codec.sv
// Directed bench for bcd_xs3_codec with DIGITS=4: encode/decode, sweep,
// invalid digits, backpressure, mid-conversion reset and back-to-back flow.
module tb_bcd_xs3_codec;

  localparam int DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
  logic [3:0]  out_err_mask;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bcd_xs3_codec #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err),
    .out_err_mask (out_err_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference digit conversion: returns {bad, value}.
  function automatic logic [4:0] ref_digit(input logic mode, input logic [3:0] d);
    if (mode == 1'b0) begin
      if (d inside {[4'd0:4'd9]}) return {1'b0, 4'(d + 4'd3)};
      return 5'h1F;
    end
    if (d inside {[4'd3:4'd12]}) return {1'b0, 4'(d - 4'd3)};
    return 5'h1F;
  endfunction

  // Offers one word, waits for its result, drains it when out_ready is high.
  task automatic xfer(input logic mode, input logic [15:0] data,
                      output logic [15:0] res, output logic [3:0] mask,
                      output logic err, output int lat, output bit ok);
    int n;
    ok = 1'b1; res = '0; mask = '0; err = 1'b0; lat = 0;
    in_mode = mode; in_data = data; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin ok = 1'b0; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'hFFFF; in_mode = ~mode;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) ok = 1'b0;
    res = out_data; mask = out_err_mask; err = out_err;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0)     begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (out_err !== 1'b0)       begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    checks++; if (out_err_mask !== 4'h0)  begin errors++; $display("FAIL reset_mask: got %b expected 0000", out_err_mask); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rdy_before_edge: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rdy_after_release: got %b expected 1", in_ready); end
  endtask

  task automatic test_encode();
    logic [15:0] r; logic [3:0] m; logic e; int lat; bit ok;
    out_ready = 1'b1;
    xfer(1'b0, 16'h1234, r, m, e, lat, ok);
    checks++; if (ok !== 1'b1)   begin errors++; $display("FAIL enc_timeout: got %b expected 1", ok); end
    checks++; if (r !== 16'h4567) begin errors++; $display("FAIL enc_data: got %h expected 4567", r); end
    checks++; if (e !== 1'b0)     begin errors++; $display("FAIL enc_err: got %b expected 0", e); end
    checks++; if (lat != DIGITS)  begin errors++; $display("FAIL enc_latency: got %0d expected %0d", lat, DIGITS); end
  endtask

  task automatic test_decode();
    logic [15:0] r; logic [3:0] m; logic e; int lat; bit ok;
    xfer(1'b1, 16'h4567, r, m, e, lat, ok);
    checks++; if (ok !== 1'b1)    begin errors++; $display("FAIL dec_timeout: got %b expected 1", ok); end
    checks++; if (r !== 16'h1234) begin errors++; $display("FAIL dec_data: got %h expected 1234", r); end
    checks++; if (m !== 4'b0000)  begin errors++; $display("FAIL dec_mask: got %b expected 0000", m); end
  endtask

  task automatic test_sweep();
    logic [15:0] r, d, exp_d; logic [3:0] m, exp_m; logic e; int lat; bit ok;
    logic [4:0] rd;
    for (int mode = 0; mode < 2; mode++) begin
      for (int w = 0; w < 16; w++) begin
        for (int p = 0; p < 4; p++) begin
          d[4*p +: 4] = 4'((w + p) % 16);
          rd = ref_digit(1'(mode), d[4*p +: 4]);
          exp_d[4*p +: 4] = rd[3:0];
          exp_m[p] = rd[4];
        end
        xfer(1'(mode), d, r, m, e, lat, ok);
        checks++;
        if (ok !== 1'b1 || r !== exp_d || m !== exp_m || e !== (|exp_m)) begin
          errors++;
          $display("FAIL sweep m%0d in=%h: got %h/%b/%b expected %h/%b/%b",
                   mode, d, r, m, e, exp_d, exp_m, |exp_m);
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [15:0] r; logic [3:0] m; logic e; int lat; bit ok;
    xfer(1'b0, 16'h09A9, r, m, e, lat, ok);
    checks++; if (r !== 16'h3CFC) begin errors++; $display("FAIL inv_enc_data: got %h expected 3CFC", r); end
    checks++; if (m !== 4'b0010)  begin errors++; $display("FAIL inv_enc_mask: got %b expected 0010", m); end
    checks++; if (e !== 1'b1)     begin errors++; $display("FAIL inv_enc_err: got %b expected 1", e); end
    xfer(1'b1, 16'h2D33, r, m, e, lat, ok);
    checks++; if (r !== 16'hFF00) begin errors++; $display("FAIL inv_dec_data: got %h expected FF00", r); end
    checks++; if (m !== 4'b1100)  begin errors++; $display("FAIL inv_dec_mask: got %b expected 1100", m); end
    checks++; if (e !== 1'b1)     begin errors++; $display("FAIL inv_dec_err: got %b expected 1", e); end
  endtask

  task automatic test_backpressure();
    logic [15:0] r; logic [3:0] m; logic e; int lat; bit ok; int n;
    out_ready = 1'b0;
    xfer(1'b0, 16'h0555, r, m, e, lat, ok);
    checks++; if (ok !== 1'b1 || r !== 16'h3888) begin errors++; $display("FAIL bp_first: got %h expected 3888", r); end
    in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h8642;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_data !== 16'h3888 || out_err_mask !== 4'h0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got data=%h mask=%b rdy=%b vld=%b expected 3888/0000/0/1",
                 i, out_data, out_err_mask, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain: got vld=%b rdy=%b expected 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: got rdy=%b expected 0", in_ready); end
    in_valid = 1'b0; n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hB975) begin errors++; $display("FAIL bp_second: got %h vld=%b expected B975/1", out_data, out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; logic [3:0] m; logic e; int lat; bit ok;
    out_ready = 1'b1; in_mode = 1'b0; in_data = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || out_err !== 1'b0 || out_err_mask !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b vld=%b data=%h err=%b mask=%b expected all zero",
               in_ready, out_valid, out_data, out_err, out_err_mask);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rdy: got %b expected 1", in_ready); end
    xfer(1'b0, 16'h9870, r, m, e, lat, ok);
    checks++; if (ok !== 1'b1 || r !== 16'hCBA3) begin errors++; $display("FAIL mid_fresh: got %h expected CBA3", r); end
  endtask

  task automatic test_back_to_back();
    logic        modes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] words [4] = '{16'h0123, 16'h3456, 16'h9999, 16'hCCCC};
    logic [15:0] exps  [4] = '{16'h3456, 16'h0123, 16'hCCCC, 16'h9999};
    logic [15:0] res   [4];
    int acc [4];
    int k, got, t;
    logic rdy_before;
    k = 0; got = 0; t = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = modes[0]; in_data = words[0];
    while (got < 4 && t < 200) begin
      rdy_before = in_ready;
      @(posedge clk); #1; t++;
      if (rdy_before && k < 4) begin
        acc[k] = cyc; k++;
        if (k < 4) begin in_mode = modes[k]; in_data = words[k]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin res[got] = out_data; got++; end
    end
    in_valid = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", got); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (i < k && acc[i] - acc[i-1] != DIGITS + 2) begin
        errors++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, acc[i] - acc[i-1], DIGITS + 2);
      end else if (i >= k) begin
        errors++; $display("FAIL b2b_spacing%0d: got no acceptance expected one", i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got || res[i] !== exps[i]) begin
        errors++; $display("FAIL b2b_result%0d: got %h expected %h", i, (i < got) ? res[i] : 16'h0, exps[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_decode();
    test_sweep();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
